// File: rtl/bh_pkg.sv
// ---------------------------------------------------------------------------
// bh_pkg
//   Shared definitions for the Bluetooth test-path message source:
//   FSM state encoding, message byte constants, CR/LF constants and the
//   message length for both build configurations.
//   Build macro: BH_MSG_CRLF_EN (defined -> message is followed by CR LF).
// ---------------------------------------------------------------------------
package bh_pkg;

  // Sequencer states of bh_msg_source
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FIRE = 2'd2,
    ST_GAP  = 2'd3
  } bh_state_e;

  // Message "BT OK!"
  localparam logic [7:0] MSG_B0 = 8'h42;  // 'B'
  localparam logic [7:0] MSG_B1 = 8'h54;  // 'T'
  localparam logic [7:0] MSG_B2 = 8'h20;  // ' '
  localparam logic [7:0] MSG_B3 = 8'h4F;  // 'O'
  localparam logic [7:0] MSG_B4 = 8'h4B;  // 'K'
  localparam logic [7:0] MSG_B5 = 8'h21;  // '!'
  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;

  localparam int unsigned IDX_W        = 32'd3;
  localparam int unsigned MSG_LEN_BASE = 32'd6;
  localparam int unsigned MSG_LEN_CRLF = 32'd8;

`ifdef BH_MSG_CRLF_EN
  localparam int unsigned MSG_LEN = MSG_LEN_CRLF;
`else
  localparam int unsigned MSG_LEN = MSG_LEN_BASE;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 32'd1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);

endpackage

// File: rtl/bh_msg_rom.sv
// ---------------------------------------------------------------------------
// bh_msg_rom
//   Combinational message lookup: byte index -> ASCII byte.
//   Build macro: BH_MSG_CRLF_EN (defined -> indices 6,7 return CR, LF).
// Ports
//   idx_i   in  IDX_W  byte index within the message
//   byte_o  out 8      message byte at idx_i (8'h00 outside the message)
// ---------------------------------------------------------------------------
module bh_msg_rom
  import bh_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output logic [7:0]       byte_o
);

  // Index-to-byte table; indices past the message read as zero
  always_comb begin
    byte_o = 8'h00;
    case (idx_i)
      3'd0:    byte_o = MSG_B0;
      3'd1:    byte_o = MSG_B1;
      3'd2:    byte_o = MSG_B2;
      3'd3:    byte_o = MSG_B3;
      3'd4:    byte_o = MSG_B4;
      3'd5:    byte_o = MSG_B5;
`ifdef BH_MSG_CRLF_EN
      3'd6:    byte_o = CHR_CR;
      3'd7:    byte_o = CHR_LF;
`endif
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/bh_msg_source.sv
// ---------------------------------------------------------------------------
// bh_msg_source
//   Upstream feeder for uart_send. Debounces the user key and, on each
//   accepted press seen while idle, streams the fixed message byte by byte
//   using a one-cycle uart_en strobe with uart_din held. Bytes are paced by an
//   internal gap counter because uart_send exposes no busy flag.
//   Build macro: BH_MSG_CRLF_EN (defined -> CR LF appended, same pacing).
// Ports
//   sys_clk    in   1  system clock, rising edge
//   sys_rst_n  in   1  asynchronous active-low reset
//   key        in   1  raw push-button, active-low, asynchronous
//   uart_en    out  1  one-cycle start strobe to uart_send
//   uart_din   out  8  byte to transmit, held from LOAD to the next LOAD
//   busy       out  1  high while a message is in flight
// ---------------------------------------------------------------------------
module bh_msg_source
  import bh_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 32'd50_000_000,
  parameter int unsigned UART_BPS   = 32'd9600,
  parameter int unsigned DEB_CYCLES = 32'd1_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key,
  output logic       uart_en,
  output logic [7:0] uart_din,
  output logic       busy
);

  // Strobe-to-strobe period: 10-bit frame plus 2 bit times of margin
  localparam int unsigned BYTE_GAP = (CLK_FREQ / UART_BPS) * 32'd12;
  localparam int unsigned GAP_W    = $clog2(BYTE_GAP);
  localparam int unsigned DEB_W    = (DEB_CYCLES > 32'd1) ? $clog2(DEB_CYCLES) : 32'd1;

  // FIRE + (BYTE_GAP-2) GAP cycles + LOAD gives exactly BYTE_GAP cycles per byte
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_GAP - 32'd2);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(32'd1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 32'd1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(32'd1);

  logic             key_meta_q;
  logic             key_sync_q;
  logic             key_prev_q;
  logic             key_deb_q,  key_deb_d;
  logic [DEB_W-1:0] deb_cnt_q,  deb_cnt_d;
  logic             press_q,    press_d;
  bh_state_e        state_q,    state_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic [GAP_W-1:0] gap_q,      gap_d;
  logic             uart_en_q,  uart_en_d;
  logic [7:0]       uart_din_q, uart_din_d;
  logic             busy_q,     busy_d;
  logic [7:0]       rom_byte_s;

  bh_msg_rom u_rom (
    .idx_i  (idx_q),
    .byte_o (rom_byte_s)
  );

  // Debounce: count consecutive stable samples that disagree with the debounced value
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    key_deb_d = key_deb_q;
    if (key_sync_q != key_prev_q) begin
      deb_cnt_d = {DEB_W{1'b0}};
    end else if (key_sync_q == key_deb_q) begin
      deb_cnt_d = {DEB_W{1'b0}};
    end else if (deb_cnt_q == DEB_LAST) begin
      key_deb_d = key_sync_q;
      deb_cnt_d = {DEB_W{1'b0}};
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_ONE;
    end
    // Press is the debounced 1->0 edge, registered as a single-cycle pulse
    press_d = key_deb_q & ~key_deb_d;
  end

  // Message sequencer next-state; outputs are derived from the next state so they register cleanly
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    uart_din_d = uart_din_q;
    case (state_q)
      ST_IDLE: begin
        // Only presses seen here start a message; presses elsewhere are dropped
        if (press_q) begin
          state_d = ST_LOAD;
          idx_d   = {IDX_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        uart_din_d = rom_byte_s;
        state_d    = ST_FIRE;
      end
      ST_FIRE: begin
        gap_d   = {GAP_W{1'b0}};
        state_d = ST_GAP;
      end
      ST_GAP: begin
        gap_d = gap_q + GAP_ONE;
        if (gap_d == GAP_LAST) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = {IDX_W{1'b0}};
          end else begin
            state_d = ST_LOAD;
            idx_d   = idx_q + IDX_ONE;
          end
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {IDX_W{1'b0}};
        gap_d   = {GAP_W{1'b0}};
      end
    endcase
    uart_en_d = (state_d == ST_FIRE);
    busy_d    = (state_d != ST_IDLE);
  end

  // Key synchroniser, debounce and sequencer state registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      key_prev_q <= 1'b1;
      key_deb_q  <= 1'b1;
      deb_cnt_q  <= {DEB_W{1'b0}};
      press_q    <= 1'b0;
      state_q    <= ST_IDLE;
      idx_q      <= {IDX_W{1'b0}};
      gap_q      <= {GAP_W{1'b0}};
      uart_en_q  <= 1'b0;
      uart_din_q <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      key_meta_q <= key;
      key_sync_q <= key_meta_q;
      key_prev_q <= key_sync_q;
      key_deb_q  <= key_deb_d;
      deb_cnt_q  <= deb_cnt_d;
      press_q    <= press_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      uart_en_q  <= uart_en_d;
      uart_din_q <= uart_din_d;
      busy_q     <= busy_d;
    end
  end

  assign uart_en  = uart_en_q;
  assign uart_din = uart_din_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bh_msg_source.sv
module tb_bh_msg_source;

  localparam int BYTE_GAP = 144;

  typedef struct packed {
    logic [7:0] data;
    logic       is_first;
  } exp_t;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       key;
  logic       uart_en;
  logic [7:0] uart_din;
  logic       busy;

  exp_t exp_q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   cyc        = 0;
  int   strobe_cnt = 0;
  int   last_strobe = 0;
  int   fall_cyc   = 0;
  logic prev_en    = 1'b0;
  logic prev_busy  = 1'b0;
  logic busy_seen  = 1'b0;

  logic [7:0] msg_bytes [0:7];
  int         msg_len;

  bh_msg_source #(
    .CLK_FREQ   (120),
    .UART_BPS   (10),
    .DEB_CYCLES (4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key       (key),
    .uart_en   (uart_en),
    .uart_din  (uart_din),
    .busy      (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Monitor: pops the scoreboard on every strobe, checks byte, width, spacing, busy
  always @(negedge sys_clk) begin
    exp_t e;
    cyc++;
    if (busy === 1'b1) busy_seen = 1'b1;
    if (prev_busy === 1'b1 && busy === 1'b0) fall_cyc = cyc;
    if (uart_en === 1'b1) begin
      strobe_cnt++;
      checks++;
      if (prev_en === 1'b1) begin
        failures++;
        $display("FAIL uart_en_width actual=2+cycles required=1 cycle at cyc %0d", cyc);
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_at_strobe actual=%b required=1", busy);
      end
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual din=%h required=no strobe", uart_din);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (uart_din !== e.data) begin
          failures++;
          $display("FAIL uart_din actual=%h required=%h", uart_din, e.data);
        end
        if (!e.is_first) begin
          checks++;
          if (cyc - last_strobe != BYTE_GAP) begin
            failures++;
            $display("FAIL strobe_spacing actual=%0d required=%0d", cyc - last_strobe, BYTE_GAP);
          end
        end
      end
      last_strobe = cyc;
    end
    prev_en   = uart_en;
    prev_busy = busy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_msg();
    for (int i = 0; i < msg_len; i++) begin
      exp_q.push_back('{data: msg_bytes[i], is_first: (i == 0)});
    end
  endtask

  task automatic press(input int n_low);
    tick(1);
    key = 1'b0;
    tick(n_low);
    key = 1'b1;
  endtask

  // Bounded wait for busy to rise and then fall
  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (busy !== 1'b1 && t < 200) begin
      @(negedge sys_clk);
      t++;
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy_rise actual=timeout required=busy high", name);
    end
    t = 0;
    while (busy !== 1'b0 && t < 2000) begin
      @(negedge sys_clk);
      t++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_fall actual=timeout required=busy low", name);
    end
    tick(2);
  endtask

  initial begin
    int base;
    msg_bytes[0] = 8'h42; msg_bytes[1] = 8'h54; msg_bytes[2] = 8'h20; msg_bytes[3] = 8'h4F;
    msg_bytes[4] = 8'h4B; msg_bytes[5] = 8'h21; msg_bytes[6] = 8'h0D; msg_bytes[7] = 8'h0A;
`ifdef BH_MSG_CRLF_EN
    msg_len = 8;
`else
    msg_len = 6;
`endif

    // Reset state
    sys_rst_n = 1'b0;
    key       = 1'b1;
    tick(3);
    check("rst_uart_en", {31'd0, uart_en}, 32'd0);
    check("rst_uart_din", {24'd0, uart_din}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    sys_rst_n = 1'b1;
    tick(10);

    // 1: single press sends the full message
    base = strobe_cnt;
    push_msg();
    press(20);
    wait_done("t1");
    check("t1_count", strobe_cnt - base, msg_len);
    check("t1_queue_empty", exp_q.size(), 32'd0);
    check("t1_busy_tail", fall_cyc - last_strobe, BYTE_GAP - 1);
    check("t1_din_hold", {24'd0, uart_din}, {24'd0, msg_bytes[msg_len-1]});

    // 2: bouncing key never reaches a stable low
    base = strobe_cnt;
    busy_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      key = ~key;
      tick(2);
    end
    key = 1'b1;
    tick(200);
    check("t2_no_strobe", strobe_cnt - base, 32'd0);
    check("t2_busy_low", {31'd0, busy_seen}, 32'd0);

    // 3: press during message is dropped; re-press in idle sends again
    base = strobe_cnt;
    push_msg();
    press(20);
    tick(300);
    press(20);
    wait_done("t3a");
    check("t3_first_count", strobe_cnt - base, msg_len);
    check("t3_queue_empty_a", exp_q.size(), 32'd0);
    push_msg();
    press(20);
    wait_done("t3b");
    check("t3_second_count", strobe_cnt - base, 2 * msg_len);
    check("t3_queue_empty_b", exp_q.size(), 32'd0);

    // 4: reset in the third byte's gap aborts; next press restarts at the first byte
    base = strobe_cnt;
    push_msg();
    press(20);
    begin
      int t;
      t = 0;
      while (strobe_cnt - base < 3 && t < 1000) begin
        tick(1);
        t++;
      end
    end
    check("t4_reached_byte3", strobe_cnt - base, 32'd3);
    tick(20);
    sys_rst_n = 1'b0;
    #1;
    check("t4_rst_uart_en", {31'd0, uart_en}, 32'd0);
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    check("t4_rst_uart_din", {24'd0, uart_din}, 32'd0);
    exp_q.delete();
    tick(5);
    sys_rst_n = 1'b1;
    tick(300);
    check("t4_no_resume", strobe_cnt - base, 32'd3);
    base = strobe_cnt;
    push_msg();
    press(20);
    wait_done("t4");
    check("t4_restart_count", strobe_cnt - base, msg_len);
    check("t4_queue_empty", exp_q.size(), 32'd0);

    // 6: key held low sends exactly one message
    base = strobe_cnt;
    push_msg();
    tick(1);
    key = 1'b0;
    tick(2000);
    check("t6_count", strobe_cnt - base, msg_len);
    check("t6_queue_empty", exp_q.size(), 32'd0);
    key = 1'b1;
    tick(50);
    check("t6_release_no_send", strobe_cnt - base, msg_len);
    check("t6_busy_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
